// File: rtl/sp_ram_burst_reader.sv
// Burst read initiator for the single-port word RAM: sequential reads out to a valid/ready stream.
// Optional XOR checksum of the streamed words is built when SP_RAM_BURST_CSUM_EN is defined.
module sp_ram_burst_reader #(
  parameter int RAM_SIZE   = 32768,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [LEN_WIDTH-1:0]  req_len_i,
  input  logic                  abort_i,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [31:0]           ram_wdata_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  input  logic [31:0]           ram_rdata_i,
  output logic                  data_valid_o,
  input  logic                  data_ready_i,
  output logic [31:0]           data_o,
  output logic                  data_last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [31:0]           csum_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic                  zero_done_q;

  // Two-entry output FIFO; a word arriving into an empty FIFO is presented directly.
  logic [31:0]           fifo_data [2];
  logic                  fifo_last [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q;

  logic                  accept, issue, pop, push, bypass, flush, drain_done, last_issue;
  logic [2:0]            occ_after_pop;

  assign ram_wdata_o = 32'h0;
  assign ram_we_o    = 1'b0;
  assign ram_be_o    = 4'hF;

  assign req_ready_o  = (state_q == ST_IDLE) && !abort_i && !rst_i;
  assign accept       = req_valid_i && req_ready_o;
  assign busy_o       = (state_q != ST_IDLE);
  assign flush        = busy_o && abort_i;

  assign data_valid_o = (count_q != 2'd0) || inflight_q;
  assign data_o       = (count_q != 2'd0) ? fifo_data[rd_ptr_q] : ram_rdata_i;
  assign data_last_o  = (count_q != 2'd0) ? fifo_last[rd_ptr_q] : inflight_last_q;
  assign pop          = data_valid_o && data_ready_i;
  assign push         = inflight_q;
  assign bypass       = push && pop && (count_q == 2'd0);

  // Words held or owed to the FIFO once this cycle's pop is taken out.
  assign occ_after_pop = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue         = (state_q == ST_RUN) && !abort_i && (occ_after_pop < 3'd2);
  assign last_issue    = issue && (remaining_q == LEN_WIDTH'(1));
  assign ram_en_o      = issue;
  assign ram_addr_o    = addr_q;
  assign next_addr     = (addr_q == ADDR_WIDTH'(RAM_SIZE - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);

  assign drain_done    = (state_q == ST_DRAIN) && (count_q == 2'd0) && !inflight_q;
  assign done_o        = zero_done_q || (drain_done && !abort_i);

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept && (req_len_i != '0)) state_d = ST_RUN;
      ST_RUN: begin
        if (abort_i)         state_d = ST_IDLE;
        else if (last_issue) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (abort_i || drain_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      zero_done_q     <= 1'b0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
    end else begin
      state_q     <= state_d;
      zero_done_q <= accept && (req_len_i == '0);

      if (accept) begin
        addr_q      <= req_addr_i;
        remaining_q <= req_len_i;
      end else if (issue) begin
        addr_q      <= next_addr;
        remaining_q <= remaining_q - LEN_WIDTH'(1);
      end

      if (flush) begin
        inflight_q      <= 1'b0;
        inflight_last_q <= 1'b0;
        wr_ptr_q        <= 1'b0;
        rd_ptr_q        <= 1'b0;
        count_q         <= 2'd0;
      end else begin
        inflight_q      <= issue;
        inflight_last_q <= last_issue;
        if (push && !bypass)             wr_ptr_q <= ~wr_ptr_q;
        if (pop && (count_q != 2'd0))    rd_ptr_q <= ~rd_ptr_q;
        if (!bypass) count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  // NOTE: FIFO storage is not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push && !bypass && !flush) begin
      fifo_data[wr_ptr_q] <= ram_rdata_i;
      fifo_last[wr_ptr_q] <= inflight_last_q;
    end
  end

`ifdef SP_RAM_BURST_CSUM_EN
  logic [31:0] csum_q;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i)                csum_q <= 32'h0;
    else if (accept)          csum_q <= 32'h0;
    else if (pop && !flush)   csum_q <= csum_q ^ data_o;
  end

  assign csum_o = csum_q;
`else
  assign csum_o = 32'h0;
`endif

endmodule

// File: tb/tb_sp_ram_burst_reader.sv
// Self-checking bench for sp_ram_burst_reader: directed bursts plus randomized bursts and
// backpressure, compared against an address/data model of the RAM contents.
module tb_sp_ram_burst_reader;

  localparam int RAM_SIZE = 1024;
  localparam int AW       = $clog2(RAM_SIZE);
  localparam int LW       = AW + 1;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          req_valid, req_ready_o;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic          abort;
  logic          ram_en_o;
  logic [AW-1:0] ram_addr_o;
  logic [31:0]   ram_wdata_o;
  logic          ram_we_o;
  logic [3:0]    ram_be_o;
  logic [31:0]   ram_rdata;
  logic          data_valid_o, data_ready;
  logic [31:0]   data_o;
  logic          data_last_o, busy_o, done_o;
  logic [31:0]   csum_o;

  sp_ram_burst_reader #(.RAM_SIZE(RAM_SIZE)) dut (
    .clk          (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr),
    .req_len_i    (req_len),
    .abort_i      (abort),
    .ram_en_o     (ram_en_o),
    .ram_addr_o   (ram_addr_o),
    .ram_wdata_o  (ram_wdata_o),
    .ram_we_o     (ram_we_o),
    .ram_be_o     (ram_be_o),
    .ram_rdata_i  (ram_rdata),
    .data_valid_o (data_valid_o),
    .data_ready_i (data_ready),
    .data_o       (data_o),
    .data_last_o  (data_last_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .csum_o       (csum_o)
  );

  always #5 clk = ~clk;

  // RAM with one-cycle read latency
  logic [31:0] mem [RAM_SIZE];
  always @(posedge clk) if (ram_en_o) ram_rdata <= mem[ram_addr_o];

  int tests = 0;
  int fails = 0;

  int          cyc = 0;
  int          accept_cyc, first_en, last_en, first_valid, last_pop, done_cyc, done_cnt, busy_cnt;
  int          issued_addr [$];
  logic [31:0] got_data [$];
  logic        got_last [$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;
  logic        track = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already set at the negedge; sample 1ns later, then advance.
  task automatic tick();
    #1;
    if (prev_stall) begin
      check("stall_valid", data_valid_o, 1);
      check("stall_data", data_o, prev_data);
      check("stall_last", data_last_o, prev_last);
    end
    if (ram_en_o) begin
      issued_addr.push_back(int'(ram_addr_o));
      if (first_en < 0) first_en = cyc;
      last_en = cyc;
    end
    if (data_valid_o && first_valid < 0) first_valid = cyc;
    if (data_valid_o && data_ready) begin
      got_data.push_back(data_o);
      got_last.push_back(data_last_o);
      last_pop = cyc;
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy_o) busy_cnt++;
    if (track) check("outstanding_le2", (issued_addr.size() - got_data.size()) <= 2, 1);
    prev_stall = data_valid_o && !data_ready && !abort;
    prev_data  = data_o;
    prev_last  = data_last_o;
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic ready_val(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 3) == 0;
    return logic'($urandom % 2);
  endfunction

  function automatic logic [31:0] model_csum(input int a, input int n);
    logic [31:0] x = 32'h0;
    for (int i = 0; i < n; i++) x ^= mem[(a + i) % RAM_SIZE];
    return x;
  endfunction

  task automatic start_burst(input int a, input int l, input int mode, input string tag);
    issued_addr.delete();
    got_data.delete();
    got_last.delete();
    first_en = -1; last_en = -1; first_valid = -1; last_pop = -1;
    done_cyc = -1; done_cnt = 0; busy_cnt = 0;
    req_valid  = 1'b1;
    req_addr   = AW'(a);
    req_len    = LW'(l);
    data_ready = ready_val(mode, 0);
    #1 check({tag, "_req_ready"}, req_ready_o, 1);
    accept_cyc = cyc;
    track = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic run_to_done(input int mode, input int budget, input string tag);
    int k = 1;
    while (done_cnt == 0 && k < budget) begin
      data_ready = ready_val(mode, k);
      tick();
      k++;
    end
    check({tag, "_done_seen"}, done_cnt != 0, 1);
    data_ready = 1'b1;
    repeat (3) tick();
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_busy_after"}, busy_o, 0);
    check({tag, "_ready_after"}, req_ready_o, 1);
    track = 1'b0;
  endtask

  task automatic verify_words(input int a, input int l, input int n, input logic with_last, input string tag);
    check({tag, "_words"}, got_data.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < got_data.size()) begin
        check($sformatf("%s_data%0d", tag, i), got_data[i], mem[(a + i) % RAM_SIZE]);
        check($sformatf("%s_last%0d", tag, i), got_last[i], with_last && (i == l - 1));
      end
    end
  endtask

  task automatic verify_burst(input int a, input int l, input string tag);
    check({tag, "_reads"}, issued_addr.size(), l);
    for (int i = 0; i < l; i++)
      if (i < issued_addr.size())
        check($sformatf("%s_addr%0d", tag, i), issued_addr[i], (a + i) % RAM_SIZE);
    verify_words(a, l, l, 1'b1, tag);
`ifdef SP_RAM_BURST_CSUM_EN
    check({tag, "_csum"}, csum_o, model_csum(a, l));
`else
    check({tag, "_csum"}, csum_o, 32'h0);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ram_en"}, ram_en_o, 0);
    check({tag, "_ram_addr"}, ram_addr_o, 0);
    check({tag, "_valid"}, data_valid_o, 0);
    check({tag, "_last"}, data_last_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_csum"}, csum_o, 0);
    check({tag, "_req_ready"}, req_ready_o, 0);
  endtask

  initial begin
    int a, l, n_issued;
    rst_i = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; abort = 1'b0; data_ready = 1'b0;
    for (int i = 0; i < RAM_SIZE; i++) mem[i] = $urandom;
    mem[16] = 32'hA0A0_0000; mem[17] = 32'hA1A1_1111;
    mem[18] = 32'hA2A2_2222; mem[19] = 32'hA3A3_3333;

    #2 check_reset_outputs("reset");
    check("const_we", ram_we_o, 0);
    check("const_be", ram_be_o, 4'hF);
    check("const_wdata", ram_wdata_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
    tick();

    // Full-throughput burst with timing checks
    start_burst(16, 4, 0, "b4");
    run_to_done(0, 50, "b4");
    verify_burst(16, 4, "b4");
    check("b4_first_en", first_en, accept_cyc + 1);
    check("b4_last_en", last_en, accept_cyc + 4);
    check("b4_first_valid", first_valid, accept_cyc + 2);
    check("b4_last_pop", last_pop, accept_cyc + 5);
    check("b4_done_cyc", done_cyc, accept_cyc + 6);

    // Same burst under 1,0,0 backpressure
    start_burst(16, 4, 1, "bp");
    run_to_done(1, 100, "bp");
    verify_burst(16, 4, "bp");

    // Address wrap at the top of the RAM
    start_burst(1022, 4, 2, "wrap");
    run_to_done(2, 200, "wrap");
    verify_burst(1022, 4, "wrap");

    // Zero-length request
    start_burst(5, 0, 0, "len0");
    run_to_done(0, 10, "len0");
    check("len0_done_cyc", done_cyc, accept_cyc + 1);
    check("len0_no_en", first_en, -1);
    check("len0_no_valid", first_valid, -1);
    check("len0_busy", busy_cnt, 0);
    check("len0_csum", csum_o, 0);

    // Abort after three words popped
    a = int'($urandom_range(0, RAM_SIZE - 1));
    start_burst(a, 8, 0, "abort");
    for (int k = 0; k < 20 && got_data.size() < 3; k++) begin
      data_ready = 1'b1;
      tick();
    end
    abort = 1'b1; data_ready = 1'b0; track = 1'b0;
    tick();
    abort = 1'b0; data_ready = 1'b1;
    n_issued = issued_addr.size();
    #1;
    check("abort_valid", data_valid_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_ram_en", ram_en_o, 0);
    check("abort_req_ready", req_ready_o, 1);
    repeat (4) tick();
    check("abort_no_done", done_cnt, 0);
    check("abort_no_reads", issued_addr.size(), n_issued);
    verify_words(a, 8, 3, 1'b0, "abort");
`ifdef SP_RAM_BURST_CSUM_EN
    check("abort_csum", csum_o, model_csum(a, 3));
`else
    check("abort_csum", csum_o, 32'h0);
`endif
    start_burst(0, 1, 0, "post_abort");
    run_to_done(0, 20, "post_abort");
    verify_burst(0, 1, "post_abort");

    // Asynchronous reset in the middle of a burst
    start_burst(100, 8, 0, "rst");
    repeat (3) tick();
    #3 rst_i = 1'b1;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk);
    rst_i = 1'b0;
    data_ready = 1'b0;
    tick();
    check("rst_no_done", done_cnt, 0);
    start_burst(200, 2, 0, "post_rst");
    run_to_done(0, 20, "post_rst");
    verify_burst(200, 2, "post_rst");

    // Randomized bursts with random backpressure
    for (int t = 0; t < 8; t++) begin
      a = int'($urandom_range(0, RAM_SIZE - 1));
      l = int'($urandom_range(1, 10));
      start_burst(a, l, 2, $sformatf("rnd%0d", t));
      run_to_done(2, 400, $sformatf("rnd%0d", t));
      verify_burst(a, l, $sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sp_ram_burst_reader.md
Name: sp_ram_burst_reader

Overview:
- Initiator for the single-port word RAM interface (en/addr/wdata/we/be/rdata, 1-cycle read latency).
- Accepts a burst request (start word address, word count) and issues sequential RAM reads.
- Returns the read words on a valid/ready stream with last-word marking and full backpressure.
- Used by boot/debug/DMA-style paths to read instruction or data RAM contents out.

Parameters:
RAM_SIZE, 32768, RAM depth in 32-bit words
ADDR_WIDTH, $clog2(RAM_SIZE), word address width
LEN_WIDTH, ADDR_WIDTH+1, width of burst length field

Ports:
clk  input  1  clock
rst_i  input  1  reset; asynchronous, active-high
req_valid_i  input  1  burst request valid
req_ready_o  output  1  request accepted when valid&ready
req_addr_i  input  ADDR_WIDTH  start word address
req_len_i  input  LEN_WIDTH  number of words; 0 legal
abort_i  input  1  synchronous burst abort
ram_en_o  output  1  RAM access enable
ram_addr_o  output  ADDR_WIDTH  RAM word address
ram_wdata_o  output  32  constant 0
ram_we_o  output  1  constant 0
ram_be_o  output  4  constant 4'hF
ram_rdata_i  input  32  RAM read data, valid 1 cycle after ram_en_o
data_valid_o  output  1  stream data valid
data_ready_i  input  1  stream consumer ready
data_o  output  32  read word
data_last_o  output  1  final word of burst
busy_o  output  1  burst in progress
done_o  output  1  one-cycle pulse at burst completion
csum_o  output  32  burst checksum (see Optional Feature)

Behaviour:
- Reset (async, rst_i=1): FSM=IDLE, FIFO empty, no read in flight; ram_en_o=0, data_valid_o=0, data_last_o=0, busy_o=0, done_o=0, csum_o=0, req_ready_o=0 while rst_i is high; ram_addr_o=0.
- FSM states:
  - IDLE: req_ready_o=1. On accept with len>0 -> RUN; latch addr and remaining=len.
  - On accept with len=0: done_o pulses the next cycle, no RAM access, stay IDLE.
  - RUN: issue reads. When the last read is issued -> DRAIN.
  - DRAIN: when the FIFO is empty and no read is in flight -> done_o=1 for one cycle -> IDLE.
- busy_o=1 in RUN and DRAIN.
- Latency: request accepted in cycle T -> first ram_en_o in T+1 -> first data_valid_o in T+2 (FIFO write-through allowed when empty).
- Buffering: 2-entry output FIFO plus 1 in-flight read.
  - Issue a read in a cycle only when (FIFO occupancy + in-flight − pop this cycle) < 2.
  - With data_ready_i held high, throughput is 1 word/cycle.
  - With data_ready_i low, the FIFO never overflows, reads stall, and ram_en_o=0.
- Address increments by 1 per issued read. After RAM_SIZE-1 it wraps to 0.
- data_last_o accompanies the word corresponding to the len-th read. Stream handshake is AXI-style: data_o, data_last_o and data_valid_o are held stable while valid&!ready.
- abort_i in RUN/DRAIN:
  - Next cycle: FSM=IDLE, FIFO flushed, in-flight return data discarded, ram_en_o=0.
  - No done_o pulse and no data_last_o.
  - abort_i in IDLE is ignored; a simultaneous request is not accepted that cycle.
- Requests arriving while busy stall: req_ready_o=0 until IDLE.
- rst_i during a burst aborts it asynchronously. Outputs return to reset values and no done_o is produced.

Optional Feature:
- Macro: SP_RAM_BURST_CSUM_EN.
- Defined: csum_o = XOR of all words popped from the stream in the current burst.
  - Cleared to 0 on request accept.
  - Final value stable from the done_o cycle until the next accept.
  - Left unchanged on abort.
- Undefined: csum_o tied to 32'h0; no checksum logic is synthesized.

Test Plan:
- RAM preloaded [0x10..0x13]=A0,A1,A2,A3; req addr=0x10 len=4, ready=1 -> ram_en_o in 4 consecutive cycles starting T+1, addrs 0x10..0x13. Data A0..A3 in T+2..T+5, data_last_o with A3, done_o once after. With CSUM_EN: csum=A0^A1^A2^A3.
- Same burst, data_ready_i toggled 1,0,0,1,... -> no word lost or duplicated, data_o stable while stalled, ram_en_o=0 while FIFO+in-flight=2.
- RAM_SIZE=1024, addr=1022 len=4 -> read addrs 1022,1023,0,1; last on 4th word.
- len=0 -> no ram_en_o, no data_valid_o, done_o pulse the cycle after accept, busy_o stays 0.
- len=8, abort_i asserted after 3 words popped -> IDLE next cycle, data_valid_o=0, no done_o; next request addr=0 len=1 completes normally.
- rst_i asserted mid-burst (not clock-aligned) -> all outputs immediately at reset values; after release, a new len=2 burst completes correctly.
